// File: rtl/pattern_generator_if.sv
// rtl/pattern_generator_if.sv - bit-plane stream and control bundle between pattern generator and driver controller
interface pattern_generator_if #(
  parameter int NB_DRIVERS = 30
);
  logic                  driver_ready;
  logic                  button;
  logic [NB_DRIVERS-1:0] data;
  logic                  frame_start;
  logic [1:0]            mode;

  modport master (
    input  driver_ready,
    input  button,
    output data,
    output frame_start,
    output mode
  );

  modport slave (
    output driver_ready,
    output button,
    input  data,
    input  frame_start,
    input  mode
  );
endinterface

// File: rtl/pattern_generator.sv
// rtl/pattern_generator.sv - arithmetic poker-mode test-pattern source with four button-selected modes
module pattern_generator #(
  parameter int NB_DRIVERS     = 30,
  parameter int LED_PER_DRIVER = 16,
  parameter int POKER_MODE     = 9,
  parameter int NB_COLUMNS     = 8
) (
  input logic                 clk_33,
  input logic                 nrst,
  pattern_generator_if.master bus
);

  localparam int LED_W = (LED_PER_DRIVER > 1) ? $clog2(LED_PER_DRIVER) : 1;
  localparam int BIT_W = (POKER_MODE > 1) ? $clog2(POKER_MODE) : 1;
  localparam int COL_W = (NB_COLUMNS > 1) ? $clog2(NB_COLUMNS) : 1;

  localparam logic [LED_W-1:0] LED_LAST = LED_W'(LED_PER_DRIVER - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(POKER_MODE - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(NB_COLUMNS - 1);
  // First poker bit that carries channel data; lower bits are zero padding.
  localparam logic [BIT_W-1:0] OFF5     = BIT_W'(POKER_MODE - 5);
  localparam logic [BIT_W-1:0] OFF6     = BIT_W'(POKER_MODE - 6);

  typedef enum logic [1:0] {
    CH_B = 2'd0,
    CH_G = 2'd1,
    CH_R = 2'd2
  } chan_e;

  typedef enum logic [1:0] {
    MODE_SOLID  = 2'd0,
    MODE_BARS   = 2'd1,
    MODE_COLUMN = 2'd2,
    MODE_WALK   = 2'd3
  } mode_e;

  chan_e                 rgb;
  logic [LED_W-1:0]      led;
  logic [BIT_W-1:0]      bit_idx;
  logic [COL_W-1:0]      col;
  logic [1:0]            anim;
  logic [LED_W-1:0]      walk;
  mode_e                 mode_q;
  logic                  pending;
  logic                  sync_meta;
  logic                  sync_stable;
  logic                  sync_prev;
  logic [NB_DRIVERS-1:0] data_q;
  logic                  frame_start_q;

  logic [NB_DRIVERS-1:0] pixel_bits;
  logic                  last_rgb;
  logic                  last_led;
  logic                  last_bit;
  logic                  last_col;
  logic                  frame_end;
  logic                  at_frame_start;
  logic                  btn_edge;

  // RGB565 pixel for driver d under the current mode and counter state.
  function automatic logic [15:0] pixel_of(
    input int               d,
    input mode_e            m,
    input logic [LED_W-1:0] led_v,
    input logic [COL_W-1:0] col_v,
    input logic [1:0]       anim_v,
    input logic [LED_W-1:0] walk_v
  );
    logic [4:0]  k;
    int          s;
    logic [15:0] p;
    k = 5'(col_v);
    s = (d + int'(led_v) + int'(anim_v)) % 3;
    case (m)
      MODE_SOLID:  p = 16'hFFFF;
      MODE_BARS: begin
        case (s)
          0:       p = 16'h001F;
          1:       p = 16'h07E0;
          default: p = 16'hF800;
        endcase
      end
      MODE_COLUMN: p = {k, k, 1'b0, k};
      default:     p = (led_v == walk_v) ? 16'hFFFF : 16'h0000;
    endcase
    return p;
  endfunction

  // Select the channel and return its MSB-aligned bit for the current poker plane.
  function automatic logic poker_bit(
    input logic [15:0]      p,
    input chan_e            ch_sel,
    input logic [BIT_W-1:0] b
  );
    logic [5:0]       ch;
    logic [BIT_W-1:0] off;
    logic [BIT_W-1:0] ix;
    case (ch_sel)
      CH_B: begin
        ch  = {1'b0, p[15:11]};
        off = OFF5;
      end
      CH_G: begin
        ch  = p[10:5];
        off = OFF6;
      end
      default: begin
        ch  = {1'b0, p[4:0]};
        off = OFF5;
      end
    endcase
    ix = b - off;
    return (b >= off) && (|(ch & (6'd1 << ix)));
  endfunction

  assign last_rgb       = (rgb == CH_R);
  assign last_led       = (led == '0);
  assign last_bit       = (bit_idx == '0);
  assign last_col       = (col == COL_LAST);
  assign frame_end      = bus.driver_ready && last_rgb && last_led && last_bit && last_col;
  assign at_frame_start = (rgb == CH_B) && (led == LED_LAST) && (bit_idx == BIT_LAST) && (col == '0);
  assign btn_edge       = sync_stable && !sync_prev;

  // Per-driver poker bit for the counter state about to be emitted.
  always_comb begin
    pixel_bits = '0;
    for (int d = 0; d < NB_DRIVERS; d++) begin
      pixel_bits[d] = poker_bit(pixel_of(d, mode_q, led, col, anim, walk), rgb, bit_idx);
    end
  end

  // Two-flop synchroniser plus history flop for rising-edge detection of the button.
  always_ff @(posedge clk_33 or negedge nrst) begin
    if (!nrst) begin
      sync_meta   <= 1'b0;
      sync_stable <= 1'b0;
      sync_prev   <= 1'b0;
    end else begin
      sync_meta   <= bus.button;
      sync_stable <= sync_meta;
      sync_prev   <= sync_stable;
    end
  end

  // Scan counters, registered output plane, and per-frame animation state.
  always_ff @(posedge clk_33 or negedge nrst) begin
    if (!nrst) begin
      rgb           <= CH_B;
      led           <= LED_LAST;
      bit_idx       <= BIT_LAST;
      col           <= '0;
      anim          <= 2'd0;
      walk          <= '0;
      data_q        <= '0;
      frame_start_q <= 1'b0;
    end else if (bus.driver_ready) begin
      data_q        <= pixel_bits;
      frame_start_q <= at_frame_start;
      case (rgb)
        CH_B:    rgb <= CH_G;
        CH_G:    rgb <= CH_R;
        default: rgb <= CH_B;
      endcase
      if (last_rgb) begin
        led <= last_led ? LED_LAST : led - 1'b1;
        if (last_led) begin
          bit_idx <= last_bit ? BIT_LAST : bit_idx - 1'b1;
          if (last_bit) begin
            col <= last_col ? '0 : col + 1'b1;
          end
        end
      end
      if (frame_end) begin
        anim <= (anim == 2'd2) ? 2'd0 : anim + 2'd1;
        walk <= (walk == LED_LAST) ? '0 : walk + 1'b1;
      end
    end else begin
      data_q        <= '0;
      frame_start_q <= 1'b0;
    end
  end

  // Mode stepping: a button edge arms one step, which is taken at the next frame end.
  always_ff @(posedge clk_33 or negedge nrst) begin
    if (!nrst) begin
      mode_q  <= MODE_SOLID;
      pending <= 1'b0;
    end else if (frame_end) begin
      if (pending) begin
        mode_q <= mode_e'(mode_q + 2'd1);
      end
      pending <= btn_edge;
    end else if (btn_edge) begin
      pending <= 1'b1;
    end
  end

  assign bus.data        = data_q;
  assign bus.frame_start = frame_start_q;
  assign bus.mode        = mode_q;

endmodule

// File: tb/tb_pattern_generator.sv
// tb/tb_pattern_generator.sv - self-checking bench for pattern_generator
module tb_pattern_generator;

  localparam int ND    = 30;
  localparam int NL    = 16;
  localparam int NP    = 9;
  localparam int NC    = 8;
  localparam int FRAME = 3 * NL * NP * NC;
  localparam logic [ND-1:0] ONES = '1;
  localparam logic [ND-1:0] D0   = 30'h09249249;
  localparam logic [ND-1:0] D1   = 30'h12492492;
  localparam logic [ND-1:0] D2   = 30'h24924924;

  logic clk_33 = 1'b0;
  logic nrst   = 1'b0;

  pattern_generator_if #(.NB_DRIVERS(ND)) bus ();

  pattern_generator #(
    .NB_DRIVERS(ND),
    .LED_PER_DRIVER(NL),
    .POKER_MODE(NP),
    .NB_COLUMNS(NC)
  ) dut (
    .clk_33(clk_33),
    .nrst(nrst),
    .bus(bus)
  );

  always #15 clk_33 = ~clk_33;

  typedef struct {
    logic [ND-1:0] data;
    logic          fs;
    logic [1:0]    mode;
  } exp_t;

  typedef struct {
    int            frame;
    int            n;
    logic [ND-1:0] data;
    logic          fs;
    logic [1:0]    mode;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[$];
  bit   hit[$];

  int tests_run    = 0;
  int tests_failed = 0;
  int cycle        = 0;

  int m_n, m_frame, m_anim, m_walk, m_mode;
  bit m_pend, m_s1, m_s2, m_s3;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic add_vec(input int f, input int n, input logic [ND-1:0] d, input logic fs, input logic [1:0] m);
    vec_t v;
    v.frame = f; v.n = n; v.data = d; v.fs = fs; v.mode = m;
    vecs.push_back(v);
    hit.push_back(1'b0);
  endtask

  task automatic model_reset();
    m_n = 0; m_frame = 0; m_anim = 0; m_walk = 0; m_mode = 0;
    m_pend = 0; m_s1 = 0; m_s2 = 0; m_s3 = 0;
    sb_q.delete();
  endtask

  function automatic logic model_bit(input int d);
    int rgb, led, bt, col, w, sel;
    logic [15:0] p;
    logic [5:0]  ch;
    logic [4:0]  k;
    rgb = m_n % 3;
    led = NL - 1 - (m_n / 3) % NL;
    bt  = NP - 1 - (m_n / (3 * NL)) % NP;
    col = m_n / (3 * NL * NP);
    k   = 5'(col % 32);
    case (m_mode)
      0: p = 16'hFFFF;
      1: begin
        sel = (d + led + m_anim) % 3;
        p = (sel == 0) ? 16'h001F : (sel == 1) ? 16'h07E0 : 16'hF800;
      end
      2: p = {k, k, 1'b0, k};
      default: p = (led == m_walk) ? 16'hFFFF : 16'h0000;
    endcase
    if (rgb == 0) begin ch = {1'b0, p[15:11]}; w = 5; end
    else if (rgb == 1) begin ch = p[10:5]; w = 6; end
    else begin ch = {1'b0, p[4:0]}; w = 5; end
    if (bt < NP - w) return 1'b0;
    return ch[3'(bt - (NP - w))];
  endfunction

  task automatic step(input logic r, input logic b);
    exp_t e;
    exp_t q;
    int   out_frame, out_n;
    bit   edge_det;
    bus.driver_ready = r;
    bus.button       = b;
    out_frame = m_frame;
    out_n     = m_n;
    e.data = '0;
    e.fs   = 1'b0;
    if (r) begin
      for (int d = 0; d < ND; d++) e.data[d] = model_bit(d);
      e.fs = (m_n == 0);
    end
    edge_det = m_s2 && !m_s3;
    if (r && m_n == FRAME - 1) begin
      m_anim = (m_anim + 1) % 3;
      m_walk = (m_walk + 1) % NL;
      if (m_pend) m_mode = (m_mode + 1) % 4;
      m_pend  = edge_det;
      m_n     = 0;
      m_frame++;
    end else begin
      if (edge_det) m_pend = 1'b1;
      if (r) m_n++;
    end
    m_s3 = m_s2; m_s2 = m_s1; m_s1 = b;
    e.mode = 2'(m_mode);
    sb_q.push_back(e);
    @(posedge clk_33);
    #1;
    cycle++;
    if (sb_q.size() == 0) begin
      check("sb_empty", 64'd1, 64'd0);
    end else begin
      q = sb_q.pop_front();
      check($sformatf("sb@%0d", cycle), {bus.data, bus.frame_start, bus.mode}, {q.data, q.fs, q.mode});
    end
    if (r) begin
      foreach (vecs[i]) begin
        if (vecs[i].frame == out_frame && vecs[i].n == out_n) begin
          hit[i] = 1'b1;
          check($sformatf("vec f%0d n%0d", out_frame, out_n),
                {bus.data, bus.frame_start, bus.mode},
                {vecs[i].data, vecs[i].fs, vecs[i].mode});
        end
      end
    end
  endtask

  task automatic run(input int count, input int p0, input int p1, input int p2);
    logic b;
    for (int i = 0; i < count; i++) begin
      b = ((i >= p0) && (i < p0 + 3)) || ((i >= p1) && (i < p1 + 3)) || ((i >= p2) && (i < p2 + 3));
      step(1'b1, b);
    end
    bus.button = 1'b0;
  endtask

  initial begin
    int len;
    bus.driver_ready = 1'b0;
    bus.button       = 1'b0;
    nrst             = 1'b0;

    add_vec(0, 0,    ONES, 1'b1, 2'd0);
    add_vec(0, 1,    ONES, 1'b0, 2'd0);
    add_vec(0, 192,  ONES, 1'b0, 2'd0);
    add_vec(0, 240,  '0,   1'b0, 2'd0);
    add_vec(0, 241,  ONES, 1'b0, 2'd0);
    add_vec(0, 242,  '0,   1'b0, 2'd0);
    add_vec(0, 288,  '0,   1'b0, 2'd0);
    add_vec(0, 3455, '0,   1'b0, 2'd0);
    add_vec(1, 0,    ONES, 1'b1, 2'd0);
    add_vec(2, 3454, '0,   1'b0, 2'd0);
    add_vec(2, 3455, '0,   1'b0, 2'd1);
    add_vec(3, 0,    D2,   1'b1, 2'd1);
    add_vec(3, 1,    D1,   1'b0, 2'd1);
    add_vec(3, 2,    D0,   1'b0, 2'd1);
    add_vec(4, 0,    D1,   1'b1, 2'd1);
    add_vec(4, 1,    D0,   1'b0, 2'd1);
    add_vec(4, 2,    D2,   1'b0, 2'd1);
    add_vec(4, 3454, '0,   1'b0, 2'd1);
    add_vec(4, 3455, '0,   1'b0, 2'd2);
    add_vec(5, 2160, '0,   1'b0, 2'd2);
    add_vec(5, 2161, '0,   1'b0, 2'd2);
    add_vec(5, 2256, ONES, 1'b0, 2'd2);
    add_vec(5, 2257, ONES, 1'b0, 2'd2);
    add_vec(5, 3455, '0,   1'b0, 2'd3);
    add_vec(6, 24,   '0,   1'b0, 2'd3);
    add_vec(6, 27,   ONES, 1'b0, 2'd3);
    add_vec(15, 0,   ONES, 1'b1, 2'd3);
    add_vec(16, 0,   '0,   1'b1, 2'd3);
    add_vec(16, 42,  '0,   1'b0, 2'd3);
    add_vec(16, 45,  ONES, 1'b0, 2'd3);

    model_reset();
    repeat (3) @(posedge clk_33);
    #1;
    check("reset_outputs", {bus.data, bus.frame_start, bus.mode}, 64'd0);
    @(negedge clk_33);
    nrst = 1'b1;

    // Frame 0: continuous ready, mode 0.
    run(FRAME, -10, -10, -10);

    // Frame 1: ready toggling; next frame_start must come 2*FRAME cycles later.
    step(1'b1, 1'b0);
    len = 0;
    for (int i = 1; i <= 3 * FRAME; i++) begin
      step(logic'(i % 2 == 0), 1'b0);
      if (bus.frame_start === 1'b1) begin
        len = i;
        break;
      end
    end
    check("frame_len_toggle", 64'(len), 64'(2 * FRAME));

    // Frame 2 (rest): one button pulse mid-frame.
    run(FRAME - 1, 1000, -10, -10);
    // Frame 3: bars, anim 0.
    run(FRAME, -10, -10, -10);
    // Frame 4: bars, anim 1, three pulses -> single step.
    run(FRAME, 200, 1000, 2000);
    // Frame 5: column mode, one pulse -> walk next.
    run(FRAME, 500, -10, -10);
    // Frames 6..16: walk mode, including wrap back to led 0.
    run(11 * FRAME, -10, -10, -10);
    // Frame 17 up to col 3, bit 5.
    run(1440, -10, -10, -10);
    check("mid_column_pos", 64'(m_n), 64'd1440);

    #5;
    nrst = 1'b0;
    #1;
    check("async_reset", {bus.data, bus.frame_start, bus.mode}, 64'd0);
    model_reset();
    @(posedge clk_33);
    #1;
    check("reset_hold", {bus.data, bus.frame_start, bus.mode}, 64'd0);
    @(negedge clk_33);
    nrst = 1'b1;
    step(1'b1, 1'b0);
    check("restart", {bus.frame_start, bus.mode}, {1'b1, 2'd0});
    run(20, -10, -10, -10);

    foreach (hit[i]) check($sformatf("vec_hit %0d", i), 64'(hit[i]), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
